rle_encoder: RTL and testbench
==============================

RLE_ENCODER -- requirements
Module: rle_encoder

Interface
REQ-001 The clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-002 Parameter: LEN_W, default 8, width of the run-length field; the maximum run is MAX = 2^LEN_W - 1.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: in_valid  input  1  a 2-bit symbol is offered on in_data.
REQ-006 Port: in_ready  output  1  the block can accept a symbol this cycle.
REQ-007 Port: in_data  input  2  symbol from the upstream 1-cycle delay stage.
REQ-008 Port: in_last  input  1  this beat closes the current run (flush).
REQ-009 Port: out_valid  output  1  a token is present on out_sym/out_len.
REQ-010 Port: out_ready  input  1  the downstream consumer takes the token this cycle.
REQ-011 Port: out_sym  output  2  symbol of the head token.
REQ-012 Port: out_len  output  LEN_W  run length of the head token, range 1..MAX.

Function
REQ-013 A beat SHALL be accepted when in_valid && in_ready, and only then.
REQ-014 Run start: an accepted beat with no active run SHALL load cur_sym = in_data, set run_len = 1 and set run_active.
REQ-015 Run extend: an accepted beat with in_data == cur_sym and run_len < MAX SHALL increment run_len.
REQ-016 Symbol change: an accepted beat with in_data != cur_sym SHALL push the token (cur_sym, run_len), then restart the run with in_data at length 1.
REQ-017 Saturation: an accepted beat with in_data == cur_sym and run_len == MAX SHALL push (cur_sym, MAX), then restart the run at length 1; run_len never wraps to 0.
REQ-018 Last: an accepted beat with in_last SHALL apply REQ-014..017 first, then push the resulting run and clear run_active.
REQ-019 Change plus last on the same beat SHALL push two tokens in order: the old run, then (in_data, 1).
REQ-020 Tokens SHALL go into a 4-entry FIFO; out_valid = (count != 0); out_sym/out_len SHALL show the head entry.
REQ-021 A pop SHALL occur on out_valid && out_ready; a simultaneous push and pop SHALL be legal and SHALL keep order.
REQ-022 in_ready SHALL be (count <= 2) && !rst, decoded from registered count only, with no combinational path from out_ready.
REQ-023 Latency: a token SHALL assert out_valid on the cycle after its terminating beat is accepted.
REQ-024 Token order SHALL equal input order; no token is ever dropped or duplicated.
REQ-025 Idle cycles (in_valid = 0) SHALL neither extend nor break a run.

Reset
REQ-026 On rst: the FIFO SHALL empty, and run_active, run_len and cur_sym SHALL clear; out_valid, out_sym and out_len SHALL read 0; in_ready SHALL read 0.
REQ-027 Reset mid-run or with the FIFO non-empty SHALL discard all partial and pending data; the first accepted beat after release starts a new run.

Structure
REQ-028 Package rle_pkg SHALL hold LEN_W default, the MAX constant/function and the token typedef {sym[1:0], len[LEN_W-1:0]}.
REQ-029 The FIFO SHALL be a sub-module rle_token_fifo (4 entries, dual push ports for REQ-019, single pop, async reset).

Verification
REQ-030 Stream 10,10,10,01,01,11(last), out_ready = 1 -> tokens (2,3), (1,2), (3,1), in order, each one cycle after its closing beat.
REQ-031 Stream 00,00,01(last) -> tokens (0,2) then (1,1) on consecutive cycles; count peaks at 2 with no in_ready drop.
REQ-032 LEN_W = 3, nine beats of 11 with last on the ninth -> tokens (3,7), (3,2); out_len never reads 0.
REQ-033 out_ready = 0, stream 00,01,10,11,00 -> in_ready falls when count reaches 3; releasing out_ready drains (0,1), (1,1), (2,1), (3,1) in order with no loss.
REQ-034 Five beats of 01, then rst pulsed for one cycle -> out_valid stays 0 and no token is emitted; then 10(last) -> single token (2,1).
REQ-035 Stream 11, idle, idle, 11, idle, 11(last) -> single token (3,3).

Source files
------------

// File: rtl/rle_pkg.sv
// Shared constants, the run-length limit helper and the token layout for the RLE encoder.
package rle_pkg;

  localparam int unsigned LenWDefault = 8;

  function automatic int unsigned rle_max(input int unsigned len_w);
    return (32'd1 << len_w) - 32'd1;
  endfunction

  typedef struct packed {
    logic [1:0]             sym;
    logic [LenWDefault-1:0] len;
  } rle_token_t;

endpackage

// File: rtl/rle_token_fifo.sv
// 4-entry token FIFO with two ordered push ports (push1 only alongside push0) and one pop port.
module rle_token_fifo import rle_pkg::*; #(
  parameter int unsigned WIDTH = LenWDefault + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push0,
  input  logic [WIDTH-1:0] data0,
  input  logic             push1,
  input  logic [WIDTH-1:0] data1,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [2:0]       count
);

  logic [WIDTH-1:0] mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != 3'd0);

  // Storage is not reset; the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= data0;
    if (push1) mem[wr_ptr + 2'd1] <= data1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      wr_ptr <= wr_ptr + {1'b0, push0} + {1'b0, push1};
      if (do_pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, push0} + {2'b0, push1} - {2'b0, do_pop};
    end
  end

  assign head = (count != 3'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder for 2-bit symbols: tracks the open run and pushes (sym, len) tokens to a FIFO.
module rle_encoder import rle_pkg::*; #(
  parameter int unsigned LEN_W = LenWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_sym,
  output logic [LEN_W-1:0] out_len
);

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(rle_max(LEN_W));
  localparam int unsigned      TokW   = LEN_W + 2;

  logic             run_active;
  logic [1:0]       cur_sym;
  logic [LEN_W-1:0] run_len;
  logic [LEN_W-1:0] nxt_len;
  logic             accept;
  logic             emit_old;
  logic             push0;
  logic             push1;
  logic [TokW-1:0]  data0;
  logic [TokW-1:0]  data1;
  logic [TokW-1:0]  head;
  logic [2:0]       count;

  // Two free slots guarantee room for a change-plus-last beat even without a pop.
  assign in_ready = (count <= 3'd2) && !rst;
  assign accept   = in_valid && in_ready;
  assign emit_old = run_active && ((in_data != cur_sym) || (run_len == MaxLen));

  always_comb begin
    nxt_len = (!run_active || emit_old) ? LEN_W'(1) : run_len + LEN_W'(1);
    push0   = 1'b0;
    push1   = 1'b0;
    data0   = {cur_sym, run_len};
    data1   = {in_data, nxt_len};
    if (accept) begin
      if (emit_old) begin
        push0 = 1'b1;
        push1 = in_last;
      end else if (in_last) begin
        push0 = 1'b1;
        data0 = {in_data, nxt_len};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_active <= 1'b0;
      cur_sym    <= 2'd0;
      run_len    <= '0;
    end else if (accept) begin
      run_active <= !in_last;
      cur_sym    <= in_data;
      run_len    <= nxt_len;
    end
  end

  rle_token_fifo #(
    .WIDTH(TokW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push0 (push0),
    .data0 (data0),
    .push1 (push1),
    .data1 (data1),
    .pop   (out_ready),
    .head  (head),
    .count (count)
  );

  assign out_valid = (count != 3'd0);
  assign out_sym   = head[TokW-1:LEN_W];
  assign out_len   = head[LEN_W-1:0];

endmodule

// File: tb/tb_rle_encoder.sv
// Scoreboard bench for rle_encoder: LEN_W=8 instance plus a LEN_W=3 instance for saturation.
module tb_rle_encoder;

  typedef struct {
    int tok;
    int acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [1:0] in_data = 2'd0;
  logic       in_ready, out_valid;
  logic [1:0] out_sym;
  logic [7:0] out_len;
  logic       v3 = 1'b0, l3 = 1'b0, or3 = 1'b1;
  logic [1:0] d3 = 2'd0;
  logic       in_ready3, out_valid3;
  logic [1:0] out_sym3;
  logic [2:0] out_len3;

  int   total = 0, bad = 0, cyc = 0;
  int   lp0 = -10, lp1 = -10;
  logic strict = 1'b1;
  exp_t q0[$], q1[$];
  logic       m_act [2];
  logic [1:0] m_sym [2];
  int         m_len [2];

  rle_encoder #(.LEN_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
    .out_len(out_len)
  );

  rle_encoder #(.LEN_W(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(in_ready3), .in_data(d3),
    .in_last(l3), .out_valid(out_valid3), .out_ready(or3), .out_sym(out_sym3),
    .out_len(out_len3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int tok(input logic [1:0] s, input int len);
    return int'(s) * 1024 + len;
  endfunction

  function automatic logic rdy(input int u);
    return (u == 0) ? in_ready : in_ready3;
  endfunction

  task automatic expect_tok(input int u, input int t);
    exp_t e;
    e.tok = t;
    e.acc = cyc + 1;
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic model(input int u, input logic [1:0] s, input logic l);
    int mx;
    mx = (u == 0) ? 255 : 7;
    if (!m_act[u]) begin
      m_sym[u] = s;
      m_len[u] = 1;
    end else if (s != m_sym[u] || m_len[u] == mx) begin
      expect_tok(u, tok(m_sym[u], m_len[u]));
      m_sym[u] = s;
      m_len[u] = 1;
    end else begin
      m_len[u]++;
    end
    m_act[u] = !l;
    if (l) expect_tok(u, tok(m_sym[u], m_len[u]));
  endtask

  task automatic send(input int u, input logic [1:0] s, input logic l);
    int guard;
    guard = 0;
    if (u == 0) begin in_valid = 1'b1; in_data = s; in_last = l; end
    else begin v3 = 1'b1; d3 = s; l3 = l; end
    @(negedge clk);
    if (strict) chk("in_ready", rdy(u), 1'b1);
    while (!rdy(u) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!rdy(u)) chk("accept_timeout", 0, 1);
    else model(u, s, l);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; v3 = 1'b0; l3 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    chk({tag, "_q0_empty"}, q0.size(), 0);
    chk({tag, "_q1_empty"}, q1.size(), 0);
    chk({tag, "_idle_valid"}, out_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop and compare on every handshake; latency checked when out_ready stays high.
  always @(negedge clk) begin
    exp_t e;
    int   want_cyc;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (q0.size() == 0) begin
          chk("unexpected_tok8", tok(out_sym, int'(out_len)), 0);
        end else begin
          e = q0.pop_front();
          chk("tok8", tok(out_sym, int'(out_len)), e.tok);
          want_cyc = (e.acc > lp0 + 1) ? e.acc : lp0 + 1;
          if (strict) chk("latency8", cyc, want_cyc);
          lp0 = cyc;
        end
      end
      if (out_valid3) chk("len3_nonzero", out_len3 == 3'd0, 1'b0);
      if (out_valid3 && or3) begin
        if (q1.size() == 0) begin
          chk("unexpected_tok3", tok(out_sym3, int'(out_len3)), 0);
        end else begin
          e = q1.pop_front();
          chk("tok3", tok(out_sym3, int'(out_len3)), e.tok);
          want_cyc = (e.acc > lp1 + 1) ? e.acc : lp1 + 1;
          chk("latency3", cyc, want_cyc);
          lp1 = cyc;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_sym[i] = 2'd0; m_len[i] = 0;
    end
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sym", out_sym, 2'd0);
    chk("rst_out_len", out_len, 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Mixed stream with a change on the last beat.
    send(0, 2'd2, 0); send(0, 2'd2, 0); send(0, 2'd2, 0);
    send(0, 2'd1, 0); send(0, 2'd1, 0); send(0, 2'd3, 1);
    drain("mixed");

    send(0, 2'd0, 0); send(0, 2'd0, 0); send(0, 2'd1, 1);
    drain("change_last");

    // Saturation on the narrow instance.
    for (int i = 0; i < 9; i++) send(1, 2'd3, i == 8);
    drain("saturate");

    // Backpressure: FIFO fills to 3 and in_ready must drop.
    strict = 1'b0;
    out_ready = 1'b0;
    send(0, 2'd0, 0); send(0, 2'd1, 0); send(0, 2'd2, 0); send(0, 2'd3, 0);
    fork
      send(0, 2'd0, 0);
      begin
        #0 chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        idle(2);
        chk("bp_still_low", in_ready, 1'b0);
        out_ready = 1'b1;
      end
    join
    send(0, 2'd0, 1);
    drain("backpressure");
    strict = 1'b1;

    // Reset mid-run discards the partial run.
    for (int i = 0; i < 5; i++) send(0, 2'd1, 0);
    chk("midrun_no_valid", out_valid, 1'b0);
    rst = 1'b1;
    q0.delete(); q1.delete();
    for (int i = 0; i < 2; i++) m_act[i] = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    chk("after_rst_valid", out_valid, 1'b0);
    send(0, 2'd2, 1);
    drain("after_reset");

    // Idle gaps inside a run.
    send(0, 2'd3, 0); idle(2); send(0, 2'd3, 0); idle(1); send(0, 2'd3, 1);
    drain("idle_gaps");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
